// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment digit scanner with frame-aligned double buffering.
// Optional leading-zero blanking when SEVENSEG_LZB_EN is defined.
module seg_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank,
    output logic [3:0]            data,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   disp;
    logic [4*DIGITS-1:0]   pend;
    logic                  pend_v;
    logic                  tick;
    logic                  boundary;
    logic [3:0]            nib [DIGITS];
    logic [DIGITS-1:0]     onehot;
    logic [DIGITS-1:0]     keep;
`ifdef SEVENSEG_LZB_EN
    logic                  seen;
`endif

    assign tick     = (pcnt == PW'(PRESCALE - 1));
    assign boundary = tick && (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt       <= '0;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                pcnt <= '0;
                idx  <= boundary ? '0 : idx + IW'(1);
            end else begin
                pcnt <= pcnt + PW'(1);
            end
            // A load landing on the boundary bypasses pend so it shows with no extra frame.
            if (boundary) begin
                if (load)
                    disp <= value;
                else if (pend_v)
                    disp <= pend;
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= value;
                pend_v <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++)
            nib[i] = disp[4*i +: 4];
    end

    assign data = nib[idx];

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        keep        = '1;
`ifdef SEVENSEG_LZB_EN
        // Walk from the top digit down; digit 0 is never blanked.
        seen = 1'b0;
        for (int unsigned k = 0; k < DIGITS - 1; k++) begin
            if (nib[DIGITS-1-k] != 4'h0)
                seen = 1'b1;
            keep[DIGITS-1-k] = seen;
        end
`endif
        digit_en = blank ? '0 : (onehot & keep);
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: per-cycle vector table plus a reset-with-pending sequence.
module tb_seg_scan_mux;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int NVEC     = 96;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        blank = 1'b0;
    logic [3:0]  data;
    logic [3:0]  digit_en;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .load(load),
        .value(value),
        .blank(blank),
        .data(data),
        .digit_en(digit_en),
        .frame_done(frame_done)
    );

    typedef struct {
        logic        load;
        logic [15:0] value;
        logic        blank;
        logic [3:0]  exp_data;
        logic [3:0]  exp_en;
        logic        exp_fd;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic [3:0] en;
        logic       fd;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic logic [3:0] en_mask(input logic [15:0] v);
        logic [3:0] m = 4'b1111;
`ifdef SEVENSEG_LZB_EN
        logic s = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            if (v[4*i +: 4] != 4'h0) s = 1'b1;
            m[i] = s;
        end
`endif
        return m;
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] v, input int d);
        logic [15:0] t = v;
        return t[4*d +: 4];
    endfunction

    // Value the display should hold during cycle c of the main run.
    function automatic logic [15:0] shown(input int c);
        if (c < 16) return 16'h0000;
        if (c < 32) return 16'h1234;
        if (c < 48) return 16'h5555;
        if (c < 64) return 16'hBEEF;
        if (c < 80) return 16'h0070;
        return 16'h0000;
    endfunction

    function automatic exp_t expect_at(input int c, input logic [15:0] sh, input logic bl);
        exp_t e;
        int   d = (c / PRESCALE) % DIGITS;
        e.data = nibble(sh, d);
        e.en   = bl ? 4'b0000 : ((4'b0001 << d) & en_mask(sh));
        e.fd   = (c % (DIGITS * PRESCALE) == 0) && (c != 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            nvec++;
            nbad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " data"}, data, e.data);
            check({tag, " digit_en"}, digit_en, e.en);
            check({tag, " frame_done"}, {3'b000, frame_done}, {3'b000, e.fd});
        end
    endtask

    task automatic apply(input string tag, input logic ld, input logic [15:0] v,
                         input logic bl, input exp_t e);
        load  = ld;
        value = v;
        blank = bl;
        sb.push_back(e);
        #1;
        pop_compare(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;

        for (int c = 0; c < NVEC; c++) begin
            vecs[c].load  = 1'b0;
            vecs[c].value = '0;
            vecs[c].blank = (c >= 6) && (c <= 9);
        end
        vecs[5].load  = 1'b1; vecs[5].value  = 16'h1234;
        vecs[20].load = 1'b1; vecs[20].value = 16'hAAAA;
        vecs[25].load = 1'b1; vecs[25].value = 16'h5555;
        vecs[47].load = 1'b1; vecs[47].value = 16'hBEEF;
        vecs[50].load = 1'b1; vecs[50].value = 16'h0070;
        vecs[70].load = 1'b1; vecs[70].value = 16'h0000;
        for (int c = 0; c < NVEC; c++) begin
            e = expect_at(c, shown(c), vecs[c].blank);
            vecs[c].exp_data = e.data;
            vecs[c].exp_en   = e.en;
            vecs[c].exp_fd   = e.fd;
        end

        repeat (3) @(negedge clk);
        e.data = 4'h0; e.en = 4'b0001; e.fd = 1'b0;
        sb.push_back(e);
        #1;
        pop_compare("in_reset");

        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < NVEC; c++) begin
            if (c > 0) @(negedge clk);
            e.data = vecs[c].exp_data;
            e.en   = vecs[c].exp_en;
            e.fd   = vecs[c].exp_fd;
            apply($sformatf("main c%0d", c), vecs[c].load, vecs[c].value, vecs[c].blank, e);
        end

        // Reset mid-frame with a value pending: it must never reach the display.
        @(negedge clk);
        load = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            apply($sformatf("pre_rst c%0d", c), c == 3, 16'h9876, 1'b0,
                  expect_at(c, 16'h0000, 1'b0));
        end
        @(negedge clk);
        load = 1'b0;
        reset_n = 1'b0;
        e.data = 4'h0; e.en = 4'b0001; e.fd = 1'b0;
        sb.push_back(e);
        #1;
        pop_compare("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (c > 0) @(negedge clk);
            apply($sformatf("post_rst c%0d", c), 1'b0, 16'h0000, 1'b0,
                  expect_at(c, 16'h0000, 1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scanner for a common-anode style multi-digit seven-segment display. Holds a DIGITS-nibble hexadecimal value, steps through the digits at a programmable refresh rate, and presents one 4-bit nibble per scan slot to the downstream `sevenseg` decoder together with a one-hot digit enable. New values are double-buffered and take effect only at a frame boundary, so a displayed frame never mixes old and new digits.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- PRESCALE, 50000, clk cycles each digit stays enabled (>=2)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- load  in  1  one-cycle strobe: capture `value` for display
- value  in  4*DIGITS  digit i = value[4i+3:4i]; digit 0 rightmost
- blank  in  1  high: all digit enables forced low (scanning continues)
- data  out  4  current digit nibble, drives `sevenseg` data input
- digit_en  out  DIGITS  one-hot active-high enable of current digit
- frame_done  out  1  one-cycle pulse when scan wraps from digit DIGITS-1 to 0

## Operation
- Registers: prescaler `pcnt` (0..PRESCALE-1), digit index `idx` (0..DIGITS-1), display register `disp`, pending register `pend`, flag `pend_v`.
- pcnt increments each cycle; at PRESCALE-1 it wraps to 0 and asserts internal `tick`.
- On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1.
- Frame boundary = tick with idx==DIGITS-1.
- load without frame boundary: pend <= value, pend_v <= 1; a later load before the boundary overwrites pend (last write wins).
- At frame boundary: if load same cycle, disp <= value directly, pend_v <= 0; else if pend_v, disp <= pend, pend_v <= 0; else disp unchanged.
- data = disp nibble idx; digit_en = blank ? 0 : (1 << idx). Both decoded combinationally from registers only; no combinational path from any input except blank.
- frame_done = registered, high for the cycle after the frame-boundary tick.
- Reset (async assert, sync-safe deassert by caller): pcnt=0, idx=0, disp=0, pend=0, pend_v=0, frame_done=0; thus data=4'h0, digit_en=1 (blank low). Reset mid-frame discards pending value.

## Timing
- Each digit enabled exactly PRESCALE cycles; full frame = DIGITS*PRESCALE cycles.
- First tick after reset at cycle PRESCALE-1; idx=1 from cycle PRESCALE.
- load-to-display latency: until next frame boundary, max DIGITS*PRESCALE cycles, min 0 (same-cycle bypass visible the next cycle on digit 0).
- blank affects digit_en in the same cycle; data unaffected.
- frame_done pulse aligns with the first cycle of digit 0 in the new frame.

## Configuration
- SEVENSEG_LZB_EN defined: leading-zero blanking. digit_en bit i forced 0 when disp digit i and all higher digits are 4'h0, for i>=1; digit 0 always enabled (value 0 shows single "0"). data unchanged. Evaluated against disp, so blanking changes only at frame boundaries.
- Undefined: all digits enabled in turn regardless of value.

## Test plan
- DIGITS=4, PRESCALE=4, reset release -> digit_en 0001 cycles 0-3, 0010 cycles 4-7, 0100, 1000, back to 0001 at cycle 16 with frame_done=1 for that cycle only; data=0 throughout.
- load value=16'h1234 at cycle 5 -> data stays 0 until cycle 16, then frame reads 4,3,2,1 on digit_en 0001,0010,0100,1000.
- load 16'hAAAA then 16'h5555 in same frame -> next frame shows 5 on all digits; AAAA never displayed.
- load 16'hBEEF coincident with frame-boundary tick -> next cycle data=F, digit_en=0001; no extra frame delay.
- blank high cycles 6-9 -> digit_en=0 those cycles, idx/data progression unchanged; reset_n low at cycle 10 with pending value -> outputs to reset values immediately, pending value never shown.
- SEVENSEG_LZB_EN defined, value 16'h0070 -> digits 0,1 enabled, digits 2,3 enable low; value 16'h0000 -> only digit 0 enabled, data 0.
